// File: rtl/sipo_capture.sv
// Serial-in/parallel-out word capture with a one-word holding stage and sticky overrun.
// Define SIPO_PARITY_EN to add an even-parity bit after each word and report mismatches on par_err.
module sipo_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             d_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             busy,
    output logic             overrun,
    output logic             par_err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PAR   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] par_out_r;
    logic             par_valid_r;
    logic             busy_r;
    logic             overrun_r;
    logic             par_err_r;
    logic             par_valid_nxt_s;
    logic             busy_nxt_s;
    logic             last_bit_s;
    logic             xfer_s;
    logic [WIDTH-1:0] shifted_s;

`ifdef SIPO_PARITY_EN
    // Even parity: data XOR parity bit must be zero for a clean word.
    function automatic logic parity_err(input logic [WIDTH-1:0] word, input logic pbit);
        return (^word) ^ pbit;
    endfunction
`endif

    assign last_bit_s = (cnt_r == CW'(WIDTH - 1));
    assign xfer_s     = par_valid_r & out_ready;
    assign shifted_s  = {shift_r[WIDTH-2:0], d_in};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (d_valid) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (d_valid && last_bit_s) begin
`ifdef SIPO_PARITY_EN
                    state_nxt_s = ST_PAR;
`else
                    state_nxt_s = ST_HOLD;
`endif
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
`ifdef SIPO_PARITY_EN
            ST_PAR: begin
                if (d_valid) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
`endif
            ST_HOLD: begin
                if (xfer_s) begin
                    // A bit arriving with the transfer starts the next word.
                    state_nxt_s = d_valid ? ST_SHIFT : ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the flags are registered.
    always_comb begin
        par_valid_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        case (state_nxt_s)
            ST_SHIFT: busy_nxt_s      = 1'b1;
            ST_PAR:   busy_nxt_s      = 1'b1;
            ST_HOLD:  par_valid_nxt_s = 1'b1;
            default: begin
                par_valid_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
        endcase
    end

    // Datapath: shift register, bit count, presented word and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= {CW{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            par_out_r   <= {WIDTH{1'b0}};
            par_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            par_err_r   <= 1'b0;
        end else begin
            par_valid_r <= par_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (d_valid) begin
                        shift_r <= {{(WIDTH-1){1'b0}}, d_in};
                        cnt_r   <= CW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (d_valid) begin
                        shift_r <= shifted_s;
                        if (last_bit_s) begin
                            cnt_r <= {CW{1'b0}};
`ifndef SIPO_PARITY_EN
                            par_out_r <= shifted_s;
`endif
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                ST_PAR: begin
                    if (d_valid) begin
                        par_out_r <= shift_r;
                        par_err_r <= parity_err(shift_r, d_in);
                    end
                end
`endif
                ST_HOLD: begin
                    if (xfer_s) begin
                        par_err_r <= 1'b0;
                        if (d_valid) begin
                            shift_r <= {{(WIDTH-1){1'b0}}, d_in};
                            cnt_r   <= CW'(1);
                        end
                    end else if (d_valid) begin
                        overrun_r <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign par_out   = par_out_r;
    assign par_valid = par_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
`ifdef SIPO_PARITY_EN
    assign par_err   = par_err_r;
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_capture.sv
// Directed bench for sipo_capture (WIDTH = 8); parity cases compile in with SIPO_PARITY_EN.
module tb_sipo_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_in = 1'b0;
    logic       d_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] par_out;
    logic       par_valid;
    logic       busy;
    logic       overrun;
    logic       par_err;

    int n_tests = 0;
    int n_fail  = 0;

    sipo_capture #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .out_ready (out_ready),
        .par_out   (par_out),
        .par_valid (par_valid),
        .busy      (busy),
        .overrun   (overrun),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle just after the edge.
    task automatic tick(input logic v, input logic b, input logic r);
        d_valid   = v;
        d_in      = b;
        out_ready = r;
        @(posedge clk);
        #1;
        d_valid   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) tick(1'b1, w[i], 1'b0);
    endtask

    task automatic send_word(input logic [7:0] w);
        send_range(w, 7, 0);
`ifdef SIPO_PARITY_EN
        tick(1'b1, ^w, 1'b0);
`endif
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        d_valid   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        apply_reset();
        check("rst_par_out", par_out, 32'h0);
        check("rst_par_valid", par_valid, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_overrun", overrun, 32'h0);
        check("rst_par_err", par_err, 32'h0);

        // Plain word, no downstream ready.
        send_range(8'hB2, 7, 1);
        check("w1_busy_mid", busy, 32'h1);
        check("w1_valid_mid", par_valid, 32'h0);
        send_range(8'hB2, 0, 0);
`ifdef SIPO_PARITY_EN
        check("w1_par_state_busy", busy, 32'h1);
        check("w1_par_state_valid", par_valid, 32'h0);
        tick(1'b1, 1'b0, 1'b0);
`endif
        check("w1_valid", par_valid, 32'h1);
        check("w1_word", par_out, 32'hB2);
        check("w1_busy", busy, 32'h0);
        check("w1_par_err", par_err, 32'h0);
        tick(1'b0, 1'b0, 1'b0);
        check("w1_hold_valid", par_valid, 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        check("w1_xfer_valid", par_valid, 32'h0);
        check("w1_xfer_busy", busy, 32'h0);

        // out_ready while nothing is presented does nothing.
        tick(1'b0, 1'b0, 1'b1);
        check("idle_ready_valid", par_valid, 32'h0);
        check("idle_ready_busy", busy, 32'h0);

        // Gap of three cycles mid-word.
        send_range(8'hB2, 7, 4);
        for (int g = 0; g < 3; g++) begin
            tick(1'b0, 1'b1, 1'b0);
            check("gap_busy", busy, 32'h1);
            check("gap_valid", par_valid, 32'h0);
        end
        send_range(8'hB2, 3, 0);
`ifdef SIPO_PARITY_EN
        tick(1'b1, 1'b0, 1'b0);
`endif
        check("gap_valid_end", par_valid, 32'h1);
        check("gap_word", par_out, 32'hB2);
        check("gap_overrun", overrun, 32'h0);
        tick(1'b0, 1'b0, 1'b1);

        // Overrun: two bits arrive while the word is still held.
        send_word(8'hB2);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("ovr_word", par_out, 32'hB2);
        check("ovr_valid", par_valid, 32'h1);
        check("ovr_flag", overrun, 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        check("ovr_xfer_valid", par_valid, 32'h0);
        check("ovr_sticky", overrun, 32'h1);

        // Back-to-back: transfer and first bit of the next word in one cycle.
        apply_reset();
        check("b2b_rst_overrun", overrun, 32'h0);
        send_word(8'hB2);
        check("b2b_w1_valid", par_valid, 32'h1);
        check("b2b_w1_word", par_out, 32'hB2);
        tick(1'b1, 1'b0, 1'b1);
        check("b2b_after_xfer_valid", par_valid, 32'h0);
        check("b2b_after_xfer_busy", busy, 32'h1);
        send_range(8'h5A, 6, 0);
`ifdef SIPO_PARITY_EN
        tick(1'b1, 1'b0, 1'b0);
`endif
        check("b2b_w2_valid", par_valid, 32'h1);
        check("b2b_w2_word", par_out, 32'h5A);
        check("b2b_overrun", overrun, 32'h0);
        tick(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-word, between clock edges.
        send_range(8'hFF, 7, 3);
        check("arst_pre_busy", busy, 32'h1);
        check("arst_pre_word", par_out, 32'h5A);
        #2 rst = 1'b1;
        #1;
        check("arst_word", par_out, 32'h0);
        check("arst_busy", busy, 32'h0);
        check("arst_valid", par_valid, 32'h0);
        check("arst_overrun", overrun, 32'h0);
        #1 rst = 1'b0;
        send_word(8'h3C);
        check("arst_clean_valid", par_valid, 32'h1);
        check("arst_clean_word", par_out, 32'h3C);
        check("arst_clean_overrun", overrun, 32'h0);
        tick(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
        send_range(8'hB2, 7, 0);
        tick(1'b1, 1'b0, 1'b0);
        check("par_good_err", par_err, 32'h0);
        check("par_good_word", par_out, 32'hB2);
        tick(1'b0, 1'b0, 1'b1);
        send_range(8'hB2, 7, 0);
        tick(1'b1, 1'b1, 1'b0);
        check("par_bad_err", par_err, 32'h1);
        check("par_bad_valid", par_valid, 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        check("par_bad_cleared", par_err, 32'h0);
`else
        send_word(8'hB2);
        check("nopar_valid", par_valid, 32'h1);
        check("nopar_err", par_err, 32'h0);
        tick(1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
